// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: owns the PC control pulses and walks each instruction
// through FETCH, WAIT_MEM, EXEC, UPDATE and the CHECK boundary. It also halts on request, PC wrap or fetch timeout.
module pc_sequencer #(
    parameter int ADDR_W        = 5,
    parameter int FETCH_TIMEOUT = 15,
    parameter bit HALT_ON_WRAP  = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    output logic              fetch_en,
    input  logic              fetch_valid,
    output logic              ir_load,
    output logic              exec_req,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] pc_val,
    input  logic              pc_max_reached,
    output logic              pc_inc,
    output logic              pc_overwrite,
    output logic [ADDR_W-1:0] pc_new_val,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state
);

    localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_CHECK  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TO_W-1:0]   to_cnt_r;
    logic              halt_lat_r;
    logic              to_hit_s;
    logic              wrap_halt_s;
    logic              done_s;

    // The memory address is driven by the PC itself; the sequencer never needs its value.
    logic              pc_val_unused_s;
    assign pc_val_unused_s = ^pc_val;

    assign to_hit_s    = (to_cnt_r == TO_W'(FETCH_TIMEOUT - 1));
    assign wrap_halt_s = HALT_ON_WRAP && pc_max_reached;
    assign done_s      = (state_r == S_EXEC) && exec_done;
    assign state       = state_r;

    // Next-state selection; CHECK priority is halt latch, then wrap, then stall.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_FETCH;
                else       state_nxt_s = S_IDLE;
            end
            S_FETCH:  state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (fetch_valid)   state_nxt_s = S_EXEC;
                else if (to_hit_s) state_nxt_s = S_HALT;
                else               state_nxt_s = S_WAIT;
            end
            S_EXEC: begin
                if (exec_done) state_nxt_s = S_UPDATE;
                else           state_nxt_s = S_EXEC;
            end
            S_UPDATE: state_nxt_s = S_CHECK;
            S_CHECK: begin
                if (halt_lat_r)       state_nxt_s = S_HALT;
                else if (wrap_halt_s) state_nxt_s = S_HALT;
                else if (stall)       state_nxt_s = S_CHECK;
                else                  state_nxt_s = S_FETCH;
            end
            S_HALT: begin
                if (start) state_nxt_s = S_FETCH;
                else       state_nxt_s = S_HALT;
            end
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // State, pulse and status registers; pulses are decoded from the transition being taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            to_cnt_r     <= '0;
            halt_lat_r   <= 1'b0;
            fetch_en     <= 1'b0;
            ir_load      <= 1'b0;
            exec_req     <= 1'b0;
            pc_inc       <= 1'b0;
            pc_overwrite <= 1'b0;
            pc_new_val   <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            fault        <= 1'b0;
            retired      <= '0;
        end else begin
            state_r      <= state_nxt_s;
            fetch_en     <= (state_nxt_s == S_FETCH);
            ir_load      <= (state_r == S_WAIT) && fetch_valid;
            exec_req     <= (state_r == S_WAIT) && fetch_valid;
            pc_inc       <= done_s && !branch_taken;
            pc_overwrite <= done_s && branch_taken;
            busy         <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_HALT);
            halted       <= (state_nxt_s == S_HALT);

            if (done_s && branch_taken) pc_new_val <= branch_target;
            else                        pc_new_val <= pc_new_val;

            if (state_r == S_FETCH)
                to_cnt_r <= '0;
            else if ((state_r == S_WAIT) && !fetch_valid && !to_hit_s)
                to_cnt_r <= to_cnt_r + TO_W'(1);
            else
                to_cnt_r <= to_cnt_r;

            // A valid on the timeout cycle takes the EXEC branch, so no fault.
            if ((state_r == S_WAIT) && !fetch_valid && to_hit_s)
                fault <= 1'b1;
            else if ((state_r == S_HALT) && start)
                fault <= 1'b0;
            else
                fault <= fault;

            if ((state_nxt_s == S_HALT) && (state_r != S_HALT))
                halt_lat_r <= 1'b0;
            else if ((state_r == S_HALT) && start)
                halt_lat_r <= 1'b0;
            else if ((state_r != S_IDLE) && (state_r != S_HALT) && halt_req)
                halt_lat_r <= 1'b1;
            else
                halt_lat_r <= halt_lat_r;

            if ((state_r == S_UPDATE) && (retired != {CNT_W{1'b1}}))
                retired <= retired + CNT_W'(1);
            else
                retired <= retired;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small behavioural PC (increment, load, wrap flag).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, halt_req;
    logic        fetch_en, fetch_valid, ir_load, exec_req, exec_done;
    logic        branch_taken;
    logic [4:0]  branch_target;
    logic        pc_inc, pc_overwrite;
    logic [4:0]  pc_new_val;
    logic        busy, halted, fault;
    logic [15:0] retired;
    logic [2:0]  state;

    logic [4:0]  pc_q = 5'd0;
    logic        pc_max = 1'b0;
    int          inc_cnt = 0;
    int          ovw_cnt = 0;
    int          fetch_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          snap_inc, snap_ovw, snap_fetch;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .halt_req(halt_req),
        .fetch_en(fetch_en), .fetch_valid(fetch_valid), .ir_load(ir_load),
        .exec_req(exec_req), .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .pc_val(pc_q), .pc_max_reached(pc_max),
        .pc_inc(pc_inc), .pc_overwrite(pc_overwrite), .pc_new_val(pc_new_val),
        .busy(busy), .halted(halted), .fault(fault), .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    // Program counter driven by the sequencer pulses; flag marks an increment that wrapped.
    always @(posedge clk) begin
        if (pc_overwrite) begin
            pc_q   <= pc_new_val;
            pc_max <= 1'b0;
        end else if (pc_inc) begin
            pc_q   <= pc_q + 5'd1;
            pc_max <= (pc_q == 5'd31);
        end
    end

    // Pulse tallies sampled mid-cycle.
    always @(negedge clk) begin
        if (pc_inc)       inc_cnt   <= inc_cnt + 1;
        if (pc_overwrite) ovw_cnt   <= ovw_cnt + 1;
        if (fetch_en)     fetch_cnt <= fetch_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH to CHECK: valid after one WAIT cycle, done in first EXEC cycle.
    task automatic instr(input string tag, input logic br, input logic [4:0] tgt);
        chk({tag, "_fetch_state"}, 32'(state), 32'd1);
        chk({tag, "_fetch_en"}, 32'(fetch_en), 32'd1);
        tick();
        chk({tag, "_wait_state"}, 32'(state), 32'd2);
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        chk({tag, "_exec_state"}, 32'(state), 32'd3);
        chk({tag, "_ir_exec"}, 32'({ir_load, exec_req}), 32'd3);
        exec_done = 1'b1; branch_taken = br; branch_target = tgt;
        tick();
        exec_done = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
        chk({tag, "_update_state"}, 32'(state), 32'd4);
        chk({tag, "_pc_inc"}, 32'(pc_inc), 32'(!br));
        chk({tag, "_pc_ovw"}, 32'(pc_overwrite), 32'(br));
        tick();
        chk({tag, "_check_state"}, 32'(state), 32'd5);
        chk({tag, "_pulses_off"}, 32'({pc_inc, pc_overwrite, ir_load, exec_req}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
        fetch_valid = 1'b0; exec_done = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_flags", 32'({busy, halted, fault, fetch_en, pc_inc, pc_overwrite}), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_new_val", 32'(pc_new_val), 32'd0);

        // T1: three straight-line instructions
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        instr("t1_i0", 1'b0, 5'd0); tick();
        instr("t1_i1", 1'b0, 5'd0); tick();
        instr("t1_i2", 1'b0, 5'd0);
        chk("t1_pc", 32'(pc_q), 32'd3);
        chk("t1_retired", 32'(retired), 32'd3);
        chk("t1_inc_cnt", 32'(inc_cnt), 32'd3);
        tick();

        // T2: taken branch to 20
        instr("t2", 1'b1, 5'd20);
        chk("t2_new_val", 32'(pc_new_val), 32'd20);
        chk("t2_pc", 32'(pc_q), 32'd20);
        chk("t2_ovw_cnt", 32'(ovw_cnt), 32'd1);
        chk("t2_inc_cnt", 32'(inc_cnt), 32'd3);
        tick();
        chk("t2_fetch_addr", 32'({fetch_en, pc_q}), 32'({1'b1, 5'd20}));

        // T3: jump to 31, increment wraps to 0 and halts
        instr("t3_jmp", 1'b1, 5'd31); tick();
        instr("t3_wrap", 1'b0, 5'd0);
        chk("t3_pc", 32'(pc_q), 32'd0);
        chk("t3_flag", 32'(pc_max), 32'd1);
        tick();
        chk("t3_halt_state", 32'(state), 32'd6);
        chk("t3_halted", 32'({halted, busy}), 32'({1'b1, 1'b0}));
        tick();
        chk("t3_halt_hold", 32'(state), 32'd6);
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_restart_addr", 32'({fetch_en, pc_q}), 32'({1'b1, 5'd0}));
        instr("t3_resume", 1'b0, 5'd0);
        chk("t3_retired", 32'(retired), 32'd7);
        tick();

        // T4: fetch timeout after 15 WAIT cycles, then valid on the 15th cycle
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("t4_wait15", 32'(state), 32'd2);
        chk("t4_no_fault_yet", 32'(fault), 32'd0);
        tick();
        chk("t4_timeout_state", 32'(state), 32'd6);
        chk("t4_fault", 32'({fault, halted}), 32'd3);
        start = 1'b1; tick(); start = 1'b0;
        chk("t4_fault_clr", 32'(fault), 32'd0);
        chk("t4_refetch", 32'(state), 32'd1);
        tick();
        for (int i = 0; i < 14; i++) tick();
        fetch_valid = 1'b1; tick(); fetch_valid = 1'b0;
        chk("t4_late_valid", 32'(state), 32'd3);
        chk("t4_late_fault", 32'({fault, ir_load}), 32'd1);
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        tick(); tick();
        chk("t4_next_fetch", 32'(state), 32'd1);

        // T5: halt request during EXEC, then stall at the boundary
        tick();
        fetch_valid = 1'b1; tick(); fetch_valid = 1'b0;
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t5_exec_wait", 32'(state), 32'd3);
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        chk("t5_completes", 32'(pc_inc), 32'd1);
        tick();
        chk("t5_check", 32'(state), 32'd5);
        tick();
        chk("t5_halted", 32'(state), 32'd6);
        start = 1'b1; tick(); start = 1'b0;
        instr("t5_stall", 1'b0, 5'd0);
        stall = 1'b1;
        snap_inc = inc_cnt; snap_ovw = ovw_cnt; snap_fetch = fetch_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t5_stall_hold", 32'(state), 32'd5);
        end
        chk("t5_stall_pulses", 32'((inc_cnt - snap_inc) + (ovw_cnt - snap_ovw) + (fetch_cnt - snap_fetch)), 32'd0);
        stall = 1'b0; tick();
        chk("t5_release", 32'(state), 32'd1);

        // T6: reset in WAIT_MEM and in UPDATE
        tick();
        chk("t6_in_wait", 32'(state), 32'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_wait_rst_state", 32'(state), 32'd0);
        chk("t6_wait_rst_outs", 32'({busy, halted, fault, fetch_en, ir_load, exec_req, pc_inc, pc_overwrite}), 32'd0);
        chk("t6_wait_rst_cnt", 32'({retired, 11'd0, pc_new_val}), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        fetch_valid = 1'b1; tick(); fetch_valid = 1'b0;
        exec_done = 1'b1; tick(); exec_done = 1'b0;
        chk("t6_in_update", 32'({state, pc_inc}), 32'({3'd4, 1'b1}));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_upd_rst_state", 32'(state), 32'd0);
        chk("t6_upd_rst_outs", 32'({busy, pc_inc, pc_overwrite, retired}), 32'd0);

        // Stray inputs in IDLE are ignored, including halt_req
        halt_req = 1'b1; fetch_valid = 1'b1; exec_done = 1'b1;
        tick();
        halt_req = 1'b0; fetch_valid = 1'b0; exec_done = 1'b0;
        chk("idle_ignore", 32'({state, busy}), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        instr("final", 1'b0, 5'd0);
        tick();
        chk("final_no_halt", 32'(state), 32'd1);
        chk("final_retired", 32'(retired), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
